// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Widest supported frame; narrower frames zero-extend into this field.
  localparam int MAX_DATA_BITS = 9;

  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     parity_err;
    logic                     frame_err;
    logic                     break_det;
  } rx_entry_t;

  // Clock cycles per oversampling tick, never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    if (d < 1) begin
      d = 1;
    end else begin
      d = d;
    end
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous show-ahead FIFO; head entry is visible while not empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en_s;
  logic             rd_en_s;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot a simultaneous push into a full FIFO needs.
  always_comb begin
    rd_en_s  = pop & ~empty;
    wr_en_s  = push & (~full | rd_en_s);
    wr_ptr_d = wr_en_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
    mem_d    = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority voting and receive FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 9_600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int EW  = $bits(rx_entry_t);
  localparam parity_mode_t PMODE = parity_mode_t'(PARITY_MODE);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] T_V0      = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] T_V1      = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] T_V2      = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] T_END     = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t state_q, state_d;
  logic                 rxd_meta_q, rxd_meta_d;
  logic                 rxs_q, rxs_d;
  logic [DW-1:0]        div_cnt_q, div_cnt_d;
  logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
  logic                 v0_q, v0_d, v1_q, v1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 par_bit_q, par_bit_d;
  logic                 guard_q, guard_d;
  logic                 overrun_q, overrun_d;

  logic tick_s, vote_tick_s, end_tick_s, vote_s, last_stop_s;
  logic par_err_s, ferr_fin_s, brk_s, push_s, pop_s, drop_s, full_s, empty_s, busy_s;
  rx_entry_t entry_s, head_s;
  logic [MAX_DATA_BITS-1:0] unused_head_s;

  assign tick_s      = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST);
  assign vote_tick_s = tick_s && (samp_cnt_q == T_V2);
  assign end_tick_s  = tick_s && (samp_cnt_q == T_END);
  assign vote_s      = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);
  assign last_stop_s = (bit_cnt_q == STOP_LAST);
  assign ferr_fin_s  = ferr_q | ~vote_s;
  assign brk_s       = ferr_fin_s && (shreg_q == '0) && ((PMODE == PAR_NONE) || !par_bit_q);
  assign pop_s       = rx_valid & rx_ready;
  assign drop_s      = push_s & full_s & ~pop_s;

  // Expected parity comparison for the voted parity bit.
  always_comb begin
    case (PMODE)
      PAR_ODD:  par_err_s = ~((^shreg_q) ^ vote_s);
      PAR_EVEN: par_err_s = (^shreg_q) ^ vote_s;
      default:  par_err_s = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; STOP leaves at the last midpoint vote to catch back-to-back frames.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = (!rxs_q && !guard_q) ? ST_START : ST_IDLE;
      ST_START: begin
        if (vote_tick_s && vote_s) begin
          state_d = ST_IDLE;
        end else if (end_tick_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (end_tick_s && (bit_cnt_q == DATA_LAST)) begin
          state_d = (PMODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: state_d = end_tick_s ? ST_STOP : ST_PARITY;
      ST_STOP:   state_d = push_s ? ST_IDLE : ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: frame push strobe and busy.
  always_comb begin
    busy_s = 1'b1;
    push_s = 1'b0;
    case (state_q)
      ST_IDLE: busy_s = 1'b0;
      ST_STOP: push_s = vote_tick_s && last_stop_s;
      default: begin
        busy_s = 1'b1;
        push_s = 1'b0;
      end
    endcase
  end

  // Datapath next values: synchroniser, tick/sample counters, voter, shifter, flags.
  always_comb begin
    rxd_meta_d = rxd;
    rxs_d      = rxd_meta_q;
    div_cnt_d  = div_cnt_q;
    samp_cnt_d = samp_cnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    par_bit_d  = par_bit_q;
    guard_d    = guard_q;
    if (state_q == ST_IDLE) begin
      div_cnt_d  = '0;
      samp_cnt_d = '0;
    end else if (tick_s) begin
      div_cnt_d  = '0;
      samp_cnt_d = (samp_cnt_q == T_END) ? '0 : samp_cnt_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      div_cnt_d  = div_cnt_q + {{(DW-1){1'b0}}, 1'b1};
    end
    if (tick_s && (samp_cnt_q == T_V0)) begin
      v0_d = rxs_q;
    end else if (tick_s && (samp_cnt_q == T_V1)) begin
      v1_d = rxs_q;
    end else begin
      v0_d = v0_q;
    end
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 4'd0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        par_bit_d = 1'b0;
        guard_d   = guard_q & ~rxs_q;
      end
      ST_DATA: begin
        if (vote_tick_s) begin
          shreg_d = {vote_s, shreg_q[DATA_BITS-1:1]};
        end else if (end_tick_s) begin
          bit_cnt_d = (bit_cnt_q == DATA_LAST) ? 4'd0 : bit_cnt_q + 4'd1;
        end else begin
          shreg_d = shreg_q;
        end
      end
      ST_PARITY: begin
        if (vote_tick_s) begin
          par_bit_d = vote_s;
          perr_d    = par_err_s;
        end else begin
          par_bit_d = par_bit_q;
        end
      end
      ST_STOP: begin
        if (vote_tick_s) begin
          ferr_d  = ferr_fin_s;
          guard_d = push_s & brk_s;
        end else if (end_tick_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          ferr_d = ferr_q;
        end
      end
      default: bit_cnt_d = bit_cnt_q;
    endcase
  end

  // Sticky overrun: set when a frame is dropped, cleared by the next pop.
  always_comb begin
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (pop_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Datapath registers; synchroniser presets to the idle line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
      div_cnt_q  <= '0;
      samp_cnt_q <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= 4'd0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      guard_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxs_q      <= rxs_d;
      div_cnt_q  <= div_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      par_bit_q  <= par_bit_d;
      guard_q    <= guard_d;
      overrun_q  <= overrun_d;
    end
  end

  // Frame entry assembled from the completed shift register and flags.
  always_comb begin
    entry_s.data       = MAX_DATA_BITS'(shreg_q);
    entry_s.parity_err = perr_q;
    entry_s.frame_err  = ferr_fin_s;
    entry_s.break_det  = brk_s;
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (entry_s),
    .full  (full_s),
    .pop   (pop_s),
    .rdata (head_s),
    .empty (empty_s)
  );

  assign unused_head_s = head_s.data;
  assign rx_valid   = ~empty_s;
  assign rx_data    = rx_valid ? head_s.data[DATA_BITS-1:0] : '0;
  assign parity_err = rx_valid & head_s.parity_err;
  assign frame_err  = rx_valid & head_s.frame_err;
  assign break_det  = rx_valid & head_s.break_det;
  assign overrun    = overrun_q;
  assign busy       = busy_s;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: random and directed frames against a bit-level frame model.
module tb_uart_rx_param;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       b;
  } ent_t;

  logic clk = 1'b0;
  logic reset, line, sel, rdy0, rdy1;
  logic rxd0, rxd1;
  logic [7:0] d0, d1;
  logic v0, p0, f0, b0, o0, busy0;
  logic v1, p1, f1, b1, o1, busy1;
  int checks = 0;
  int failures = 0;
  ent_t got0[$];
  ent_t got1[$];

  always #5 clk = ~clk;

  assign rxd0 = (sel == 1'b0) ? line : 1'b1;
  assign rxd1 = (sel == 1'b1) ? line : 1'b1;

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .rxd(rxd0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
    .parity_err(p0), .frame_err(f0), .break_det(b0), .overrun(o0), .busy(busy0));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .rxd(rxd1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
    .parity_err(p1), .frame_err(f1), .break_det(b1), .overrun(o1), .busy(busy1));

  // Record every entry the consumer accepts.
  always @(negedge clk) begin
    if (!reset && v0 && rdy0) got0.push_back(ent_t'({d0, p0, f0, b0}));
    if (!reset && v1 && rdy1) got1.push_back(ent_t'({d1, p1, f1, b1}));
  end

  // Frame-level model: what the receiver should report for a given frame.
  function automatic ent_t model(input logic [7:0] d, input int pmode, input logic pbit, input logic stop);
    ent_t e;
    int ones;
    ones = $countones(d);
    e.d = d;
    e.p = 1'b0;
    if (pmode == 1) e.p = (((ones + int'(pbit)) % 2) != 1);
    if (pmode == 2) e.p = (((ones + int'(pbit)) % 2) != 0);
    e.f = (stop == 1'b0);
    e.b = e.f && (d == 8'h00) && (pmode == 0 || pbit == 1'b0);
    return e;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      line = 1'b1;
    end
  endtask

  // Drive one frame, 16 clk per bit; optionally invert one clk at the middle vote of bit glitch_bit.
  task automatic send_frame(input logic [7:0] d, input int pmode, input logic pbit,
                            input logic stop, input int glitch_bit);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pmode != 0) bits.push_back(pbit);
    bits.push_back(stop);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        line = (b == glitch_bit && c == 9) ? ~bits[b] : bits[b];
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; line = 1'b1; sel = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({v0, d0, p0, f0, b0, o0, busy0} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs0 got=%h exp=0", {v0, d0, p0, f0, b0, o0, busy0});
    end
    checks++;
    if ({v1, d1, p1, f1, b1, o1, busy1} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs1 got=%h exp=0", {v1, d1, p1, f1, b1, o1, busy1});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(8);
  endtask

  task automatic test_basic();
    ent_t exp[$];
    sel = 1'b0; rdy0 = 1'b1; got0.delete();
    send_frame(8'hA5, 0, 1'b0, 1'b1, -1); exp.push_back(model(8'hA5, 0, 1'b0, 1'b1));
    send_frame(8'h5A, 0, 1'b0, 1'b1, -1); exp.push_back(model(8'h5A, 0, 1'b0, 1'b1));
    idle(40);
    checks++;
    if (got0.size() !== exp.size()) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=%0d", got0.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== exp[i]) begin
        failures++;
        $display("FAIL basic_entry%0d got=%h exp=%h", i, got0[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    ent_t exp[$];
    logic [7:0] d;
    logic stop;
    sel = 1'b0; rdy0 = 1'b1; got0.delete();
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom_range(0, 255));
      if (n == 3) d = 8'h00;
      stop = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      send_frame(d, 0, 1'b0, stop, -1);
      exp.push_back(model(d, 0, 1'b0, stop));
      if (stop == 1'b0) idle(32);
      else idle($urandom_range(0, 5));
    end
    idle(40);
    checks++;
    if (got0.size() !== exp.size()) begin
      failures++;
      $display("FAIL random_count got=%0d exp=%0d", got0.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== exp[i]) begin
        failures++;
        $display("FAIL random_entry%0d got=%h exp=%h", i, got0[i], exp[i]);
      end
    end
  endtask

  task automatic test_parity();
    ent_t exp[$];
    logic [7:0] d;
    logic pb;
    sel = 1'b1; rdy1 = 1'b1; got1.delete();
    send_frame(8'h3C, 2, 1'b1, 1'b1, -1); exp.push_back(model(8'h3C, 2, 1'b1, 1'b1));
    idle(3);
    send_frame(8'h3C, 2, 1'b0, 1'b1, -1); exp.push_back(model(8'h3C, 2, 1'b0, 1'b1));
    for (int n = 0; n < 6; n++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 4));
      send_frame(d, 2, pb, 1'b1, -1);
      exp.push_back(model(d, 2, pb, 1'b1));
    end
    idle(40);
    sel = 1'b0;
    checks++;
    if (got1.size() !== exp.size()) begin
      failures++;
      $display("FAIL parity_count got=%0d exp=%0d", got1.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got1.size(); i++) begin
      checks++;
      if (got1[i] !== exp[i]) begin
        failures++;
        $display("FAIL parity_entry%0d got=%h exp=%h", i, got1[i], exp[i]);
      end
    end
  endtask

  task automatic test_false_start_glitch();
    ent_t exp[$];
    int seen_busy;
    sel = 1'b0; rdy0 = 1'b1; got0.delete();
    seen_busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      line = 1'b0;
    end
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      line = 1'b1;
      if (busy0) seen_busy++;
    end
    @(negedge clk);
    checks++;
    if (seen_busy == 0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL false_start_busy got=%0d/%b exp=nonzero/0", seen_busy, busy0);
    end
    idle(20);
    checks++;
    if (got0.size() !== 0) begin
      failures++;
      $display("FAIL false_start_push got=%0d exp=0", got0.size());
    end
    send_frame(8'h81, 0, 1'b0, 1'b1, 1); exp.push_back(model(8'h81, 0, 1'b0, 1'b1));
    idle(2);
    send_frame(8'h81, 0, 1'b0, 1'b1, 5); exp.push_back(model(8'h81, 0, 1'b0, 1'b1));
    idle(40);
    checks++;
    if (got0.size() !== exp.size()) begin
      failures++;
      $display("FAIL glitch_count got=%0d exp=%0d", got0.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== exp[i]) begin
        failures++;
        $display("FAIL glitch_entry%0d got=%h exp=%h", i, got0[i], exp[i]);
      end
    end
  endtask

  task automatic test_framing_break();
    ent_t exp[$];
    sel = 1'b0; rdy0 = 1'b1; got0.delete();
    send_frame(8'h33, 0, 1'b0, 1'b0, -1); exp.push_back(model(8'h33, 0, 1'b0, 1'b0));
    idle(40);
    for (int i = 0; i < 320; i++) begin
      @(posedge clk); #1;
      line = 1'b0;
    end
    exp.push_back(model(8'h00, 0, 1'b0, 1'b0));
    idle(60);
    checks++;
    if (got0.size() !== exp.size()) begin
      failures++;
      $display("FAIL break_count got=%0d exp=%0d", got0.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== exp[i]) begin
        failures++;
        $display("FAIL frame_break_entry%0d got=%h exp=%h", i, got0[i], exp[i]);
      end
    end
  endtask

  task automatic test_overrun();
    ent_t mq[$];
    logic movr;
    sel = 1'b0; rdy0 = 1'b0; movr = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 0, 1'b0, 1'b1, -1);
      if (mq.size() < 4) mq.push_back(model(8'(v), 0, 1'b0, 1'b1));
      else movr = 1'b1;
      idle(4);
    end
    idle(20);
    @(negedge clk);
    checks++;
    if (o0 !== movr || v0 !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b/%b exp=%b/1", o0, v0, movr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ent_t'({d0, p0, f0, b0}) !== mq[i]) begin
        failures++;
        $display("FAIL overrun_head%0d got=%h exp=%h", i, ent_t'({d0, p0, f0, b0}), mq[i]);
      end
      @(posedge clk); #1; rdy0 = 1'b1;
      @(posedge clk); #1; rdy0 = 1'b0;
      @(negedge clk);
      checks++;
      if (o0 !== 1'b0) begin
        failures++;
        $display("FAIL overrun_clear%0d got=%b exp=0", i, o0);
      end
    end
    checks++;
    if (v0 !== 1'b0) begin
      failures++;
      $display("FAIL overrun_drained got=%b exp=0", v0);
    end
    got0.delete();
  endtask

  task automatic test_reset_midframe();
    ent_t e;
    logic bits[$];
    sel = 1'b0; rdy0 = 1'b0; got0.delete();
    send_frame(8'h11, 0, 1'b0, 1'b1, -1);
    idle(4);
    bits.push_back(1'b0);
    for (int i = 0; i < 5; i++) bits.push_back(i[0]);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        line = (b == 5 && c == 8) ? bits[b] : bits[b];
        if (b == 5 && c == 8) reset = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if ({v0, d0, p0, f0, b0, o0, busy0} !== 14'd0) begin
      failures++;
      $display("FAIL midframe_reset_outputs got=%h exp=0", {v0, d0, p0, f0, b0, o0, busy0});
    end
    @(posedge clk); #1;
    line = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(40);
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL midframe_after_release got=%b/%b exp=0/0", v0, busy0);
    end
    rdy0 = 1'b1;
    send_frame(8'h7E, 0, 1'b0, 1'b1, -1);
    idle(40);
    e = model(8'h7E, 0, 1'b0, 1'b1);
    checks++;
    if (got0.size() !== 1) begin
      failures++;
      $display("FAIL midframe_count got=%0d exp=1", got0.size());
    end else begin
      checks++;
      if (got0[0] !== e) begin
        failures++;
        $display("FAIL midframe_entry got=%h exp=%h", got0[0], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_parity();
    test_false_start_glitch();
    test_framing_break();
    test_overrun();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1, 4x-oversampled receiver. It adds:
- configurable data width, parity and stop bits
- 3-sample majority voting and false-start rejection
- framing, parity, break and overrun detection
- a small receive FIFO with a valid/ready output handshake

It sits between the board RxD pin and the MCU peripheral bus.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
BAUD, 9_600, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, >= 8
DATA_BITS, 8, data bits per frame; 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
rxd  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  head-of-FIFO data, LSB = first bit received
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts the head entry when rx_valid & rx_ready
parity_err  out  1  head entry flag; valid with rx_valid
frame_err  out  1  head entry flag; stop bit sampled 0
break_det  out  1  head entry flag; data, parity and stop all 0
overrun  out  1  sticky: a frame was dropped because the FIFO was full
busy  out  1  FSM not in IDLE

Behaviour:
- Reset, synchronous and active-high, clock clk:
  - all outputs 0
  - FSM to IDLE; FIFO emptied
  - rxd synchroniser flops preset to 1
  - a partial frame is discarded
- Input path: rxd passes through a 2-flop synchroniser (rxs), giving 2 clk of latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division, minimum 1
  - tick is 1 clk wide every DIV clk
  - divider and sample counter are held at 0 in IDLE, so sampling phase aligns to the start edge
- Majority vote: rxs is sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit. The bit value is the majority of the three samples, latched at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rxs == 0 -> START.
  - START: voted 1 -> IDLE (false start, nothing pushed). Voted 0 -> DATA at end of bit (tick OVERSAMPLE-1).
  - DATA: shift in LSB first. After DATA_BITS bits -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: compare the voted bit against computed parity. Odd mode: data XOR parity must be 1. Even mode: it must be 0. On mismatch set parity_err for the frame. Then -> STOP.
  - STOP:
    - each stop bit is voted; any voted 0 sets frame_err
    - after the midpoint vote of the last stop bit, push the frame and go to IDLE immediately (half-bit early), so back-to-back frames are received
    - for STOP_BITS = 2, the first stop bit runs the full bit period
- break_det = frame_err AND data == 0 AND (parity bit == 0 or no parity).
- FIFO:
  - each entry holds {data, parity_err, frame_err, break_det}
  - show-ahead: rx_data and the flags reflect the head entry whenever rx_valid = 1
  - rx_valid rises on the clk edge after the push cycle, giving 1 clk push-to-valid latency
  - pop happens on the cycle where rx_valid & rx_ready
- Boundary conditions:
  - push while full and no pop: frame dropped, overrun <= 1, FIFO contents unchanged
  - push while full with simultaneous pop: both occur, no overrun
  - push and pop on an empty FIFO: push only, since rx_valid was 0
  - overrun clears on the first pop after it was set, or on reset
  - pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are decided by MSB comparison, wrapping naturally
- rxd held low forever: after a break frame is pushed, the FSM re-enters START only after rxs returns to 1. This needs an IDLE guard flag so a continuous break yields a single entry.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_t enum (NONE, ODD, EVEN)
  - rx_state_t enum
  - rx_entry_t struct {data, parity_err, frame_err, break_det}
  - a function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE
- Sub-module uart_rx_fifo is a generic synchronous show-ahead FIFO parametrised by width and depth, with push/full/pop/empty. The top level holds the synchroniser, tick generator, voter and FSM.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16 (DIV=1), and 8N1 unless noted.
- Send 0xA5 with rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, all error flags 0; then 0x5A back-to-back -> second entry 0x5A.
- PARITY_MODE=2: send 0x3C with parity bit 1 (correct is 0) -> rx_data=0x3C, parity_err=1. With parity bit 0 -> parity_err=0.
- Drive rxd low for 4 clk, then high -> no FIFO push, busy returns to 0 within one bit time. Glitching 1 of the 3 vote samples inside a data bit of 0x81 -> still reads 0x81.
- Stop bit driven 0 on 0x33 -> frame_err=1, break_det=0. rxd low for 20 bit times -> exactly one entry: data 0x00, frame_err=1, break_det=1.
- rx_ready=0, send 0x01..0x05 with FIFO_DEPTH=4 -> overrun=1 after the 5th frame; pops return 0x01..0x04 in order; overrun clears on the first pop.
- Assert reset at bit 4 of a frame, release, send 0x7E -> the partial frame is not pushed, the only entry is 0x7E, all outputs were 0 during reset.
